// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte-lane stores in one cycle, extended loads after WAIT_CYCLES.
// Optional alignment checking is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_data_i,
  input  logic [3:0]  d_we_i,
  input  logic [3:0]  d_rd_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] d_data_o,
  output logic        load_ready_o,
  output logic        err_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q;
  logic [2:0]       f3_q;
  logic [31:0]      mem [DEPTH];

  logic              rd_req, wr_req, launch, st_ok, st_err;
  logic [31:0]       cur_addr;
  logic [2:0]        cur_f3;
  logic [1:0]        off;
  logic [ADDR_W-1:0] idx;
  logic              out_of_range, misaligned, bad_f3, load_err;
  logic [31:0]       word, rot, ext, load_data, st_rot;

  // In IDLE the live request is decoded; once a load is in flight the latched one is.
  always_comb begin
    rd_req       = |d_rd_i;
    wr_req       = |d_we_i;
    cur_addr     = (state_q == S_IDLE) ? d_addr_i : addr_q;
    cur_f3       = (state_q == S_IDLE) ? funct3_i : f3_q;
    off          = cur_addr[1:0];
    idx          = cur_addr[ADDR_W+1:2];
    out_of_range = |cur_addr[31:ADDR_W+2];
    misaligned   = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
    misaligned   = ((cur_f3[1:0] == 2'b01) && off[0]) ||
                   ((cur_f3[1:0] == 2'b10) && (off != 2'b00));
`endif
    word = mem[idx];
    case (off)
      2'd1:    rot = {word[7:0],  word[31:8]};
      2'd2:    rot = {word[15:0], word[31:16]};
      2'd3:    rot = {word[23:0], word[31:24]};
      default: rot = word;
    endcase
    case (off)
      2'd1:    st_rot = {d_data_i[23:0], d_data_i[31:24]};
      2'd2:    st_rot = {d_data_i[15:0], d_data_i[31:16]};
      2'd3:    st_rot = {d_data_i[7:0],  d_data_i[31:8]};
      default: st_rot = d_data_i;
    endcase
    bad_f3 = 1'b0;
    case (cur_f3)
      3'b000:  ext = {{24{rot[7]}}, rot[7:0]};
      3'b001:  ext = {{16{rot[15]}}, rot[15:0]};
      3'b010:  ext = rot;
      3'b100:  ext = {24'h0, rot[7:0]};
      3'b101:  ext = {16'h0, rot[15:0]};
      default: begin
        ext    = 32'h0;
        bad_f3 = 1'b1;
      end
    endcase
    load_err  = out_of_range | misaligned | bad_f3;
    load_data = load_err ? 32'h0 : ext;
    launch = (state_q == S_IDLE) && rd_req && !wr_req;
    st_ok  = (state_q == S_IDLE) && wr_req && !rd_req && !out_of_range && !misaligned;
    st_err = (state_q == S_IDLE) && wr_req && (rd_req || out_of_range || misaligned);
  end

  // Load sequencing: a dropped read request during the wait abandons the load silently.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          state_d = (WAIT_CYCLES == 1) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!rd_req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      f3_q         <= '0;
      d_data_o     <= '0;
      load_ready_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (launch) begin
        addr_q <= d_addr_i;
        f3_q   <= funct3_i;
      end
      d_data_o     <= (state_d == S_DONE) ? load_data : 32'h0;
      load_ready_o <= (state_d == S_DONE);
      err_o        <= st_err | ((state_d == S_DONE) & load_err);
    end
  end

  // Array is deliberately left out of reset so stored data survives a core reset.
  always_ff @(posedge clk_i) begin
    if (st_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (d_we_i[b]) mem[idx][8*b +: 8] <= st_rot[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, hand sequences and
// randomized traffic against a byte-array reference model.
module tb_dmem_ctrl;

  localparam int ADDR_W      = 10;
  localparam int WAIT_CYCLES = 2;
  localparam int MEMB        = 4 << ADDR_W;
  localparam int NVEC        = 21;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_data_i = '0;
  logic [3:0]  d_we_i = '0;
  logic [3:0]  d_rd_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] d_data_o;
  logic        load_ready_o;
  logic        err_o;

  int check_count = 0;
  int pass_count  = 0;

  logic [7:0] ref_mem [MEMB];

  typedef struct {
    bit          is_load;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t vecs [NVEC];

  dmem_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .d_addr_i(d_addr_i), .d_data_i(d_data_i),
    .d_we_i(d_we_i), .d_rd_i(d_rd_i), .funct3_i(funct3_i),
    .d_data_o(d_data_o), .load_ready_o(load_ready_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit refOutOfRange(input logic [31:0] a);
    return a >= 32'(MEMB);
  endfunction

  function automatic bit refMisaligned(input logic [1:0] w, input logic [1:0] off);
    bit chk;
`ifdef DMEM_MISALIGN_CHK_EN
    chk = 1'b1;
`else
    chk = 1'b0;
`endif
    return chk && (((w == 2'b01) && off[0]) || ((w == 2'b10) && (off != 2'b00)));
  endfunction

  // Returns {err, data} for a load, computed byte by byte from the model array.
  function automatic logic [32:0] refLoad(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v;
    int base, off;
    if (refOutOfRange(a) || refMisaligned(f3[1:0], a[1:0])) return {1'b1, 32'h0};
    base = int'(a) & ~3;
    off  = int'(a[1:0]);
    v    = 32'h0;
    for (int i = 0; i < 4; i++) v = v | (32'(ref_mem[base + (off + i) % 4]) << (8 * i));
    case (f3)
      3'b000:  return {1'b0, (v[7]  ? 32'hFFFF_FF00 : 32'h0) | (v & 32'hFF)};
      3'b001:  return {1'b0, (v[15] ? 32'hFFFF_0000 : 32'h0) | (v & 32'hFFFF)};
      3'b010:  return {1'b0, v};
      3'b100:  return {1'b0, v & 32'hFF};
      3'b101:  return {1'b0, v & 32'hFFFF};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  function automatic bit refStore(input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] we, input logic [1:0] w);
    int base, off;
    if (refOutOfRange(a) || refMisaligned(w, a[1:0])) return 1'b1;
    base = int'(a) & ~3;
    off  = int'(a[1:0]);
    for (int l = 0; l < 4; l++)
      if (we[l]) ref_mem[base + l] = 8'(d >> (8 * ((l - off + 4) % 4)));
    return 1'b0;
  endfunction

  task automatic applyStimulus(input logic [3:0] we, input logic [3:0] rd, input logic [31:0] addr,
                               input logic [31:0] data, input logic [2:0] f3);
    @(negedge clk_i);
    d_we_i   = we;
    d_rd_i   = rd;
    d_addr_i = addr;
    d_data_i = data;
    funct3_i = f3;
  endtask

  task automatic checkOutput(input string name, input bit exp_ready, input logic [31:0] exp_data,
                             input bit exp_err);
    check_count++;
    if (load_ready_o === exp_ready && d_data_o === exp_data && err_o === exp_err)
      pass_count++;
    else
      $display("[TB] FAIL %s: got ready=%0b data=%08h err=%0b, expected ready=%0b data=%08h err=%0b",
               name, load_ready_o, d_data_o, err_o, exp_ready, exp_data, exp_err);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic doLoad(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] exp_data,
                        input bit exp_err, input string name);
    applyStimulus(4'h0, 4'hF, addr, 32'h0, f3);
    for (int i = 1; i < WAIT_CYCLES; i++) begin
      tick();
      checkOutput({name, " wait"}, 1'b0, 32'h0, 1'b0);
    end
    tick();
    checkOutput(name, 1'b1, exp_data, exp_err);
    applyStimulus(4'h0, 4'h0, 32'h0, 32'h0, 3'b000);
    tick();
    checkOutput({name, " after"}, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic doStore(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] f3, input bit exp_err, input string name);
    applyStimulus(we, 4'h0, addr, data, f3);
    tick();
    checkOutput(name, 1'b0, 32'h0, exp_err);
    applyStimulus(4'h0, 4'h0, 32'h0, 32'h0, 3'b000);
    tick();
    checkOutput({name, " after"}, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [32:0] r;
    logic [31:0] a, d;
    logic [3:0]  we, mask;
    logic [7:0]  tmp;
    logic [2:0]  f3;
    logic [2:0]  load_codes [6];
    bit          e;

    load_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};

    vecs[0]  = '{0, 4'hF, 32'h00, 32'h0102_0304, 3'b010, 32'h0, 0};
    vecs[1]  = '{0, 4'hF, 32'h10, 32'hDEAD_BEEF, 3'b010, 32'h0, 0};
    vecs[2]  = '{1, 4'h0, 32'h10, 32'h0, 3'b010, 32'hDEAD_BEEF, 0};
    vecs[3]  = '{0, 4'h8, 32'h13, 32'h80, 3'b000, 32'h0, 0};
    vecs[4]  = '{1, 4'h0, 32'h13, 32'h0, 3'b000, 32'hFFFF_FF80, 0};
    vecs[5]  = '{1, 4'h0, 32'h13, 32'h0, 3'b100, 32'h0000_0080, 0};
    vecs[6]  = '{1, 4'h0, 32'h10, 32'h0, 3'b010, 32'h80AD_BEEF, 0};
    vecs[7]  = '{0, 4'hF, 32'h20, 32'hCAFE_F00D, 3'b010, 32'h0, 0};
    vecs[8]  = '{0, 4'hC, 32'h22, 32'h1234, 3'b001, 32'h0, 0};
    vecs[9]  = '{1, 4'h0, 32'h22, 32'h0, 3'b001, 32'h0000_1234, 0};
    vecs[10] = '{1, 4'h0, 32'h20, 32'h0, 3'b010, 32'h1234_F00D, 0};
    vecs[11] = '{1, 4'h0, 32'h1000, 32'h0, 3'b010, 32'h0, 1};
    vecs[12] = '{0, 4'hF, 32'h1000, 32'h5555_5555, 3'b010, 32'h0, 1};
    vecs[13] = '{1, 4'h0, 32'h00, 32'h0, 3'b010, 32'h0102_0304, 0};
    vecs[14] = '{1, 4'h0, 32'h12, 32'h0, 3'b101, 32'h0000_80AD, 0};
    vecs[15] = '{1, 4'h0, 32'h12, 32'h0, 3'b001, 32'hFFFF_80AD, 0};
    vecs[16] = '{1, 4'h0, 32'h10, 32'h0, 3'b011, 32'h0, 1};
    vecs[18] = '{1, 4'h0, 32'h21, 32'h0, 3'b000, 32'hFFFF_FFF0, 0};
`ifdef DMEM_MISALIGN_CHK_EN
    vecs[17] = '{1, 4'h0, 32'h11, 32'h0, 3'b010, 32'h0, 1};
    vecs[19] = '{0, 4'h9, 32'h23, 32'hABCD, 3'b001, 32'h0, 1};
    vecs[20] = '{1, 4'h0, 32'h20, 32'h0, 3'b010, 32'h1234_F00D, 0};
`else
    vecs[17] = '{1, 4'h0, 32'h11, 32'h0, 3'b010, 32'hEF80_ADBE, 0};
    vecs[19] = '{0, 4'h9, 32'h23, 32'hABCD, 3'b001, 32'h0, 0};
    vecs[20] = '{1, 4'h0, 32'h20, 32'h0, 3'b010, 32'hCD34_F0AB, 0};
`endif

    tick();
    tick();
    checkOutput("reset state", 1'b0, 32'h0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int w = 0; w < 64; w++) begin
      d = $urandom();
      void'(refStore(32'(w * 4), d, 4'hF, 2'b10));
      doStore(4'hF, 32'(w * 4), d, 3'b010, 1'b0, $sformatf("fill%0d", w));
    end

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].is_load) begin
        doLoad(vecs[i].addr, vecs[i].f3, vecs[i].exp_data, vecs[i].exp_err, $sformatf("vec%0d", i));
      end else begin
        void'(refStore(vecs[i].addr, vecs[i].data, vecs[i].we, vecs[i].f3[1:0]));
        doStore(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].f3, vecs[i].exp_err,
                $sformatf("vec%0d", i));
      end
    end

    // Simultaneous load and store strobes: no write, no load, error next cycle.
    applyStimulus(4'hF, 4'hF, 32'h10, 32'hFFFF_FFFF, 3'b010);
    tick();
    checkOutput("illegal combo", 1'b0, 32'h0, 1'b1);
    applyStimulus(4'h0, 4'h0, 32'h0, 32'h0, 3'b000);
    tick();
    checkOutput("illegal combo after", 1'b0, 32'h0, 1'b0);
    r = refLoad(32'h10, 3'b010);
    doLoad(32'h10, 3'b010, r[31:0], r[32], "illegal combo no write");

    // Read request held continuously: one pulse per WAIT_CYCLES+1 cycles.
    r = refLoad(32'h10, 3'b010);
    applyStimulus(4'h0, 4'hF, 32'h10, 32'h0, 3'b010);
    for (int c = 1; c <= 2 * (WAIT_CYCLES + 1); c++) begin
      tick();
      if (c % (WAIT_CYCLES + 1) == WAIT_CYCLES)
        checkOutput($sformatf("b2b cycle%0d", c), 1'b1, r[31:0], 1'b0);
      else
        checkOutput($sformatf("b2b cycle%0d", c), 1'b0, 32'h0, 1'b0);
    end
    applyStimulus(4'h0, 4'h0, 32'h0, 32'h0, 3'b000);
    tick();

    // Dropping the read during the wait aborts without a pulse.
    applyStimulus(4'h0, 4'hF, 32'h10, 32'h0, 3'b010);
    tick();
    applyStimulus(4'h0, 4'h0, 32'h0, 32'h0, 3'b000);
    tick();
    checkOutput("abort", 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("abort later", 1'b0, 32'h0, 1'b0);

    // Store followed immediately by a load of the same word.
    d = $urandom();
    void'(refStore(32'h44, d, 4'hF, 2'b10));
    applyStimulus(4'hF, 4'h0, 32'h44, d, 3'b010);
    tick();
    checkOutput("st then ld store", 1'b0, 32'h0, 1'b0);
    applyStimulus(4'h0, 4'hF, 32'h44, 32'h0, 3'b010);
    for (int i = 1; i < WAIT_CYCLES; i++) begin
      tick();
      checkOutput("st then ld wait", 1'b0, 32'h0, 1'b0);
    end
    tick();
    checkOutput("st then ld", 1'b1, d, 1'b0);
    applyStimulus(4'h0, 4'h0, 32'h0, 32'h0, 3'b000);
    tick();

    // Reset during a load kills it; a held request relaunches cleanly afterwards.
    applyStimulus(4'h0, 4'hF, 32'h10, 32'h0, 3'b010);
    tick();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checkOutput("reset mid-load", 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("reset held", 1'b0, 32'h0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    r = refLoad(32'h10, 3'b010);
    for (int i = 1; i < WAIT_CYCLES; i++) begin
      tick();
      checkOutput("post-reset wait", 1'b0, 32'h0, 1'b0);
    end
    tick();
    checkOutput("post-reset load", 1'b1, r[31:0], r[32]);
    applyStimulus(4'h0, 4'h0, 32'h0, 32'h0, 3'b000);
    tick();

    for (int n = 0; n < 200; n++) begin
      a = ($urandom_range(0, 9) == 0) ? ($urandom() | 32'h0000_1000) : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) begin
        f3   = 3'($urandom_range(0, 2));
        mask = (f3 == 3'b000) ? 4'h1 : (f3 == 3'b001) ? 4'h3 : 4'hF;
        tmp  = {4'h0, mask} << a[1:0];
        we   = tmp[3:0] | tmp[7:4];
        d    = $urandom();
        e    = refStore(a, d, we, f3[1:0]);
        doStore(we, a, d, f3, e, $sformatf("rnd st%0d", n));
      end else begin
        f3 = load_codes[$urandom_range(0, 5)];
        r  = refLoad(a, f3);
        doLoad(a, f3, r[31:0], r[32], $sformatf("rnd ld%0d", n));
      end
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller sitting directly downstream of the nano_rv32i core's data port. It owns a byte-addressable on-chip word array and accepts the core's combinational load/store request (address, write data, byte-lane strobes). Stores complete in one cycle. Loads return lane-aligned, sign- or zero-extended data together with a one-cycle `load_ready_o` pulse after a fixed latency, which the core's stall logic waits on.

## Interface
- `ADDR_W`, 10: word-address bits; array depth is 2^ADDR_W words (4 KiB at default).
- `WAIT_CYCLES`, 2: load latency in cycles, legal range 1..8.
- `clk_i` input 1: clock, all state updated on rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `d_addr_i` input 32: byte address from the core's ALU result.
- `d_data_i` input 32: store data, unshifted, from rs2 (byte/half in low bits).
- `d_we_i` input 4: byte-lane write strobes; nonzero means store request.
- `d_rd_i` input 4: byte-lane read enables; nonzero means load request.
- `funct3_i` input 3: RV32I load/store width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `d_data_o` output 32: extended load result, registered.
- `load_ready_o` output 1: one-cycle pulse, load result valid.
- `err_o` output 1: one-cycle pulse, access rejected.

## Operation
- Word index = `d_addr_i[ADDR_W+1:2]`. Out of range if any of `d_addr_i[31:ADDR_W+2]` is nonzero.
- Byte offset `off` = `d_addr_i[1:0]`. Store data is shifted left by 8*off. Each strobed lane writes the matching shifted byte.
- Loads read the addressed word and shift it right by 8*off.
  - B/H sign-extend from bit 7/15. BU/HU zero-extend. W passes all 32 bits.
  - Illegal funct3 returns 0 with `err_o`.
- Load FSM states:
  - IDLE: on `d_rd_i`≠0 and `d_we_i`=0, latch address/funct3 and load counter with WAIT_CYCLES-1. Go to WAIT, or to DONE if WAIT_CYCLES=1.
  - WAIT: decrement counter. At 0, go to DONE. If `d_rd_i` drops to 0, abort to IDLE with no pulse.
  - DONE: drive `load_ready_o`=1 and `d_data_o`=result for exactly one cycle, then go to IDLE. The request is still present in this cycle but is not relaunched.
- Stores are accepted only in IDLE. `d_we_i`≠0 writes at the next rising edge with no FSM transition.
- `d_we_i`≠0 and `d_rd_i`≠0 together is illegal: no write, no load, `err_o` pulses next cycle.
- Out-of-range store: suppressed, `err_o` pulses next cycle.
- Out-of-range load: goes through the normal latency, then the DONE pulse carries `d_data_o`=0 and `err_o`=1.

## Timing
- Reset values: `d_data_o`=0, `load_ready_o`=0, `err_o`=0, FSM=IDLE, counter=0. Array contents are not cleared.
- Load first seen in IDLE at cycle T → `load_ready_o` high in cycle T+WAIT_CYCLES only.
- `d_data_o` is 0 in every cycle where `load_ready_o` is low.
- Back-to-back loads: the next load is seen in IDLE at T+WAIT_CYCLES+1. Throughput is one load per WAIT_CYCLES+1 cycles.
- Store presented in cycle T is visible to a load launched in cycle T+1.
- `err_o` for stores is registered and appears one cycle after the offending edge. For loads it is coincident with `load_ready_o`.
- Reset asserted mid-load: FSM returns to IDLE immediately, no pulse is emitted, and any in-flight load is discarded.

## Configuration
- `DMEM_MISALIGN_CHK_EN` defined:
  - Halfword with `off[0]`=1, or word with `off`≠0, is rejected.
  - Store: suppressed, `err_o` next cycle.
  - Load: normal latency, then DONE pulse with data 0 and `err_o`=1.
- Undefined: no alignment check; the shift is modulo 4 within the word, so lanes wrap and no error is raised.

## Test plan
- Reset, then SW 0xDEADBEEF to 0x10 (`d_we_i`=1111), then LW 0x10 with WAIT_CYCLES=2 → `load_ready_o` high exactly 2 cycles after request, `d_data_o`=0xDEADBEEF, 0 elsewhere.
- SB 0x80 to 0x13 (`d_we_i`=1000), then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LW 0x10 → 0x80ADBEEF.
- SH 0x1234 to 0x22, then LH 0x22 → 0x00001234, with lanes 0-1 of word 0x20 unchanged.
- LW 0x0000_1000 (out of range, ADDR_W=10) → after 2 cycles `load_ready_o`=1, `d_data_o`=0, `err_o`=1. SW to the same address → no array change, `err_o` next cycle.
- With `DMEM_MISALIGN_CHK_EN` defined: LW 0x11 → `err_o`=1, data 0. Without it: LW 0x11 → word rotated right 8 bits.
- Assert `rst_i` during WAIT of a load → no `load_ready_o`. After release, a new LW completes normally and earlier stored data is intact.
